rs232_tx_scheduler: RTL and testbench
=====================================

// Module: rs232_tx_scheduler
// PURPOSE
//  Sequences the shared byte fifo on the RS232 transmit path. Round-robin arbitration
//  between two byte requesters writing into the fifo. Drains the fifo into the UART
//  transmitter with a start/busy handshake. Tracks fifo occupancy for full/empty status.
// PARAMETERS
//  DATA_WIDTH   8   width of one byte/word
//  FIFO_SIZE    16  depth of the attached fifo instance (entries)
//  POP_LATENCY  1   cycles from fifo_pop to valid fifo_out_data (1..3)
// PORTS
//  clk            in   1    system clock
//  clear          in   1    synchronous active-high reset
//  req0_valid     in   1    requester 0 offers req0_data
//  req0_data      in   DW   requester 0 byte
//  req0_ready     out  1    req0 byte accepted this cycle (valid&ready)
//  req1_valid     in   1    requester 1 offers req1_data
//  req1_data      in   DW   requester 1 byte
//  req1_ready     out  1    req1 byte accepted this cycle
//  fifo_clear     out  1    fifo clear (= clear, combinational)
//  fifo_push      out  1    single-cycle push pulse to fifo
//  fifo_in_data   out  DW   byte pushed, valid with fifo_push
//  fifo_pop       out  1    single-cycle pop pulse to fifo
//  fifo_out_data  in   DW   fifo head, valid POP_LATENCY cycles after fifo_pop
//  tx_busy        in   1    transmitter serializing
//  tx_start       out  1    single-cycle start pulse to transmitter
//  tx_data        out  DW   byte for transmitter, stable from tx_start until next tx_start
//  level          out  CW   bytes accepted and not yet popped, CW=$clog2(FIFO_SIZE+1)
//  full / empty   out  1    level==FIFO_SIZE / level==0
// BEHAVIOUR
//  Reset: all outputs 0, except empty=1. State IDLE. last_grant=1, so req0 wins first.
//  Arbiter (comb.): only when !full && !clear. Single valid requester is granted.
//   Both valid: the requester not granted last is granted. last_grant updates on accept.
//  Accept at cycle t: level+1 at t+1. fifo_push and fifo_in_data are registered at t+1.
//   Throughput is 1 byte/cycle.
//  Egress FSM: IDLE -> POP -> WAIT -> START -> HOLD -> IDLE.
//   IDLE: go POP when level!=0 && !tx_busy.
//   POP: fifo_pop=1 for one cycle. level-1.
//    If fifo_push is asserted this cycle, stay in POP with pop deferred.
//    fifo_push and fifo_pop are never high in the same cycle.
//   WAIT: POP_LATENCY cycles, then capture fifo_out_data into tx_data.
//   START: tx_start=1 for one cycle.
//   HOLD: one guard cycle, then return to IDLE once tx_busy==0.
//  level: accept and pop in the same cycle leaves level unchanged.
//   Never exceeds FIFO_SIZE. Never underflows.
//  Full: both readys low. Requesters hold valid/data until accepted. No byte is dropped.
//  clear mid-operation: FSM to IDLE, level 0, pending push and in-flight byte discarded.
//   tx_start is not asserted after clear; tx_data is zeroed.
// CONFIGURATION
//  RS232_TX_SCHED_STATS_EN defined:
//   extra out ports tx_count[15:0] (+1 per tx_start) and
//   stall_count[15:0] (+1 per cycle with any valid while full). Both wrap; cleared by clear.
//  Undefined: ports and counters absent. All other behaviour is identical.
// STRUCTURE
//  Package rs232_pkg: egress state enum typedef, DATA_WIDTH default, level width function.
//  Sub-module rr_arbiter2: 2-way round-robin grant with last_grant register.
//  Top holds push register, level counter and egress FSM.
// TESTING (FIFO_SIZE=3, POP_LATENCY=1 unless noted)
//  1 clear high 2 cycles -> all outputs 0, empty=1, fifo_clear=1 during clear, level=0.
//  2 req0 8'hAC one cycle, tx_busy=0:
//    -> fifo_push with 8'hAC next cycle, then fifo_pop, then tx_start with tx_data=8'hAC;
//    -> level 0->1->0.
//  3 req0=8'h11 and req1=8'h39 valid continuously, tx_busy=0:
//    -> readys alternate req0, req1, req0...
//    -> tx_data sequence 11,39,11...
//  4 tx_busy=1, push 8'h11, 8'h39, 8'h7D:
//    -> full=1, level=3, both readys 0, no fifo_pop, stall_count increments.
//    -> release tx_busy: pop within 2 cycles, 8'h11 sent first.
//  5 simultaneous accept and pop at level=2 -> level stays 2; push and pop in different cycles.
//  6 clear asserted during WAIT with 8'h61 in flight
//    -> no tx_start, level=0, empty=1; next byte 8'h01 transmitted normally.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared types and helpers for the RS232 transmit scheduler.
// Egress state encoding, default byte width and occupancy-counter width.
package rs232_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_WAIT,
        ST_START,
        ST_HOLD
    } egress_state_e;

    function automatic int unsigned level_width(input int unsigned fifo_size);
        return $clog2(fifo_size + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on contention the requester not granted last wins.
module rr_arbiter2 (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic grant0,
    output logic grant1
);

    // 1 means requester 1 was granted last, so requester 0 wins the next tie
    logic last_grant;

    always_comb begin
        grant0 = enable && req0_valid && (!req1_valid || last_grant);
        grant1 = enable && req1_valid && (!req0_valid || !last_grant);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            last_grant <= 1'b1;
        end else if (grant0 || grant1) begin
            last_grant <= grant1;
        end
    end

endmodule

// File: rtl/rs232_tx_scheduler.sv
// RS232 transmit scheduler: arbitrates two requesters into a byte fifo and drains it to the UART.
// Optional RS232_TX_SCHED_STATS_EN adds tx_count and stall_count output counters.
module rs232_tx_scheduler
    import rs232_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int unsigned FIFO_SIZE   = 16,
    parameter int unsigned POP_LATENCY = 1
) (
    input  logic                                 clk,
    input  logic                                 clear,
    input  logic                                 req0_valid,
    input  logic [DATA_WIDTH-1:0]                req0_data,
    output logic                                 req0_ready,
    input  logic                                 req1_valid,
    input  logic [DATA_WIDTH-1:0]                req1_data,
    output logic                                 req1_ready,
    output logic                                 fifo_clear,
    output logic                                 fifo_push,
    output logic [DATA_WIDTH-1:0]                fifo_in_data,
    output logic                                 fifo_pop,
    input  logic [DATA_WIDTH-1:0]                fifo_out_data,
    input  logic                                 tx_busy,
    output logic                                 tx_start,
    output logic [DATA_WIDTH-1:0]                tx_data,
    output logic [level_width(FIFO_SIZE)-1:0]    level,
    output logic                                 full,
`ifdef RS232_TX_SCHED_STATS_EN
    output logic                                 empty,
    output logic [15:0]                          tx_count,
    output logic [15:0]                          stall_count
`else
    output logic                                 empty
`endif
);

    localparam int unsigned     CW        = level_width(FIFO_SIZE);
    localparam logic [CW-1:0]   LEVEL_ONE = CW'(1);
    localparam logic [CW-1:0]   LEVEL_MAX = CW'(FIFO_SIZE);
    localparam logic [1:0]      WAIT_LAST = 2'(POP_LATENCY - 1);

    logic grant0;
    logic grant1;
    logic accept;
    logic arb_enable;

    egress_state_e state;
    egress_state_e state_next;
    logic [1:0]    wait_cnt;
    logic          pop_now;
    logic          start_now;
    logic          capture;

    assign fifo_clear = clear;
    assign arb_enable = !full && !clear;

    rr_arbiter2 u_arbiter (
        .clk        (clk),
        .clear      (clear),
        .enable     (arb_enable),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 || grant1;

    always_ff @(posedge clk) begin
        if (clear) begin
            fifo_push    <= 1'b0;
            fifo_in_data <= '0;
        end else begin
            fifo_push <= accept;
            if (accept) begin
                fifo_in_data <= grant1 ? req1_data : req0_data;
            end
        end
    end

    // A pop is held off while the registered push is on the fifo port, so the two never coincide
    always_comb begin
        state_next = state;
        pop_now    = 1'b0;
        start_now  = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (level != '0 && !tx_busy) begin
                    state_next = ST_POP;
                end
            end
            ST_POP: begin
                if (!fifo_push) begin
                    pop_now    = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    capture    = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                start_now  = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (!tx_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign fifo_pop = pop_now && !clear;
    assign tx_start = start_now && !clear;

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            tx_data  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= (state == ST_WAIT && !capture) ? wait_cnt + 2'd1 : '0;
            if (capture) begin
                tx_data <= fifo_out_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            level <= '0;
        end else begin
            case ({accept, fifo_pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    assign full  = (level == LEVEL_MAX);
    assign empty = (level == '0);

`ifdef RS232_TX_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            tx_count    <= '0;
            stall_count <= '0;
        end else begin
            if (tx_start) begin
                tx_count <= tx_count + 16'd1;
            end
            if ((req0_valid || req1_valid) && full) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_rs232_tx_scheduler.sv
// Scoreboard bench for rs232_tx_scheduler with FIFO_SIZE=3, POP_LATENCY=1 and a queue-based fifo model.
module tb_rs232_tx_scheduler;

    logic       clk = 1'b0;
    logic       clear;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       fifo_clear, fifo_push, fifo_pop;
    logic [7:0] fifo_in_data;
    logic [7:0] fifo_out_data = 8'h00;
    logic       tx_busy, tx_start;
    logic [7:0] tx_data;
    logic [1:0] level;
    logic       full, empty;
`ifdef RS232_TX_SCHED_STATS_EN
    logic [15:0] tx_count, stall_count;
    logic [15:0] stall_snap;
`endif

    logic [7:0] push_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] fifo_q[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    rs232_tx_scheduler #(
        .DATA_WIDTH  (8),
        .FIFO_SIZE   (3),
        .POP_LATENCY (1)
    ) dut (
        .clk           (clk),
        .clear         (clear),
        .req0_valid    (req0_valid),
        .req0_data     (req0_data),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_data     (req1_data),
        .req1_ready    (req1_ready),
        .fifo_clear    (fifo_clear),
        .fifo_push     (fifo_push),
        .fifo_in_data  (fifo_in_data),
        .fifo_pop      (fifo_pop),
        .fifo_out_data (fifo_out_data),
        .tx_busy       (tx_busy),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .level         (level),
        .full          (full),
`ifdef RS232_TX_SCHED_STATS_EN
        .empty         (empty),
        .tx_count      (tx_count),
        .stall_count   (stall_count)
`else
        .empty         (empty)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fifo model: one-cycle read latency
    always @(posedge clk) begin
        if (fifo_clear) begin
            fifo_q.delete();
        end else begin
            if (fifo_push) fifo_q.push_back(fifo_in_data);
            if (fifo_pop) begin
                if (fifo_q.size() != 0) fifo_out_data <= fifo_q.pop_front();
                else fifo_out_data <= 8'hxx;
            end
        end
    end

    // Monitor: compares pushes and transmitted bytes against the scoreboard queues
    always @(negedge clk) begin
        if (!clear) begin
            if (fifo_push) begin
                if (push_q.size() == 0) fail("unexpected_push");
                else check("push_data", fifo_in_data, push_q.pop_front());
            end
            if (tx_start) begin
                if (tx_q.size() == 0) fail("unexpected_tx_start");
                else check("tx_data", tx_data, tx_q.pop_front());
            end
            if (fifo_push || fifo_pop) check("push_pop_exclusive", fifo_push && fifo_pop, 0);
        end
    end

    task automatic wait_drain(input string name);
        int unsigned n = 0;
        while ((tx_q.size() != 0 || level != 2'd0) && n < 80) begin
            tick();
            n++;
        end
        if (n >= 80) fail(name);
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] t4_bytes [3];
        int unsigned got;
        int unsigned cyc;
        logic seen;

        clear = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h55;
        req1_valid = 1'b1; req1_data = 8'hAA;
        tx_busy = 1'b0;

        // 1: reset
        tick();
        @(negedge clk);
        check("t1_fifo_clear_c1", fifo_clear, 1);
        tick();
        @(negedge clk);
        check("t1_fifo_clear", fifo_clear, 1);
        check("t1_level", level, 0);
        check("t1_empty", empty, 1);
        check("t1_full", full, 0);
        check("t1_push", fifo_push, 0);
        check("t1_pop", fifo_pop, 0);
        check("t1_tx_start", tx_start, 0);
        check("t1_tx_data", tx_data, 0);
        check("t1_readys", {req1_ready, req0_ready}, 0);
        check("t1_in_data", fifo_in_data, 0);
`ifdef RS232_TX_SCHED_STATS_EN
        check("t1_tx_count", tx_count, 0);
        check("t1_stall_count", stall_count, 0);
`endif
        tick();
        clear = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // 2: single byte end to end
        tick();
        req0_valid = 1'b1; req0_data = 8'hAC;
        push_q.push_back(8'hAC); tx_q.push_back(8'hAC);
        @(negedge clk);
        check("t2_ready0", req0_ready, 1);
        check("t2_level0", level, 0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("t2_level1", level, 1);
        check("t2_push", fifo_push, 1);
        check("t2_no_pop", fifo_pop, 0);
        tick();
        @(negedge clk);
        check("t2_pop", fifo_pop, 1);
        tick();
        @(negedge clk);
        check("t2_level_back0", level, 0);
        check("t2_empty", empty, 1);
        tick();
        @(negedge clk);
        check("t2_tx_start", tx_start, 1);
        wait_drain("t2_drain_timeout");

        clear = 1'b1;
        tick();
        clear = 1'b0;

        // 3: both requesters valid continuously
        for (int i = 0; i < 3; i++) begin
            push_q.push_back(8'h11); push_q.push_back(8'h39);
            tx_q.push_back(8'h11);   tx_q.push_back(8'h39);
        end
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h39;
        got = 0; cyc = 0;
        while (got < 6 && cyc < 100) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                check("t3_grant_order", {req1_ready, req0_ready}, (got % 2 == 0) ? 2'b01 : 2'b10);
                got++;
            end
            tick();
            cyc++;
            if (got == 6) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        if (got < 6) fail("t3_accept_timeout");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain("t3_drain_timeout");

        // 4: fill to full while transmitter busy
        tx_busy = 1'b1;
        t4_bytes[0] = 8'h11; t4_bytes[1] = 8'h39; t4_bytes[2] = 8'h7D;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1; req0_data = t4_bytes[i];
            push_q.push_back(t4_bytes[i]); tx_q.push_back(t4_bytes[i]);
            @(negedge clk);
            check("t4_fill_ready", req0_ready, 1);
            tick();
        end
        req0_data = 8'hA5;
        push_q.push_back(8'hA5); tx_q.push_back(8'hA5);
        @(negedge clk);
        check("t4_full", full, 1);
        check("t4_level", level, 3);
        check("t4_readys", {req1_ready, req0_ready}, 0);
        check("t4_no_pop", fifo_pop, 0);
`ifdef RS232_TX_SCHED_STATS_EN
        stall_snap = stall_count;
`endif
        repeat (3) begin
            tick();
            @(negedge clk);
            check("t4_stall_ready", req0_ready, 0);
            check("t4_stall_no_pop", fifo_pop, 0);
        end
`ifdef RS232_TX_SCHED_STATS_EN
        check("t4_stall_count", stall_count, stall_snap + 16'd3);
`endif
        tick();
        tx_busy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (fifo_pop) seen = 1'b1;
            tick();
        end
        check("t4_pop_within_2", seen, 1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req0_ready) seen = 1'b1;
            tick();
        end
        req0_valid = 1'b0;
        check("t4_late_accept", seen, 1);
        wait_drain("t4_drain_timeout");

        // 5: accept and pop in the same cycle at level 2
        tx_busy = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h22;
        push_q.push_back(8'h22); tx_q.push_back(8'h22);
        @(negedge clk);
        check("t5_ready_a", req0_ready, 1);
        tick();
        req0_data = 8'h33;
        push_q.push_back(8'h33); tx_q.push_back(8'h33);
        @(negedge clk);
        check("t5_ready_b", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tx_busy = 1'b0;
        @(negedge clk);
        check("t5_level2", level, 2);
        tick();
        req0_valid = 1'b1; req0_data = 8'h44;
        push_q.push_back(8'h44); tx_q.push_back(8'h44);
        @(negedge clk);
        check("t5_pop", fifo_pop, 1);
        check("t5_ready_c", req0_ready, 1);
        check("t5_level_pre", level, 2);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("t5_level_kept", level, 2);
        check("t5_push", fifo_push, 1);
        check("t5_pop_after", fifo_pop, 0);
        wait_drain("t5_drain_timeout");

        // 6: clear while byte is in flight
        req0_valid = 1'b1; req0_data = 8'h61;
        push_q.push_back(8'h61);
        @(negedge clk);
        check("t6_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick();
        @(negedge clk);
        check("t6_pop", fifo_pop, 1);
        tick();
        clear = 1'b1;
        @(negedge clk);
        check("t6_no_start_clear", tx_start, 0);
        tick();
        clear = 1'b0;
        @(negedge clk);
        check("t6_level", level, 0);
        check("t6_empty", empty, 1);
        check("t6_tx_data", tx_data, 0);
        repeat (6) tick();
        req0_valid = 1'b1; req0_data = 8'h01;
        push_q.push_back(8'h01); tx_q.push_back(8'h01);
        @(negedge clk);
        check("t6_ready_next", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        wait_drain("t6_drain_timeout");

        check("end_push_q_empty", push_q.size(), 0);
        check("end_tx_q_empty", tx_q.size(), 0);
`ifdef RS232_TX_SCHED_STATS_EN
        check("end_tx_count", tx_count, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
